alu: RTL and testbench



---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_core.sv | 63 ++++++
 rtl/alu.sv | 46 ++++
 tb/tb_alu.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the execute-stage ALU: widths and opcode encodings.
package alu_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned OP_W   = 4;

  localparam logic [OP_W-1:0] OP_ADD  = 4'b0000;
  localparam logic [OP_W-1:0] OP_SUB  = 4'b0001;
  localparam logic [OP_W-1:0] OP_AND  = 4'b0010;
  localparam logic [OP_W-1:0] OP_OR   = 4'b0011;
  localparam logic [OP_W-1:0] OP_XOR  = 4'b0100;
  localparam logic [OP_W-1:0] OP_NOT  = 4'b0101;
  localparam logic [OP_W-1:0] OP_SHL  = 4'b0110;
  localparam logic [OP_W-1:0] OP_SHR  = 4'b0111;
  localparam logic [OP_W-1:0] OP_ROL  = 4'b1000;
  localparam logic [OP_W-1:0] OP_ROR  = 4'b1001;
  localparam logic [OP_W-1:0] OP_NAND = 4'b1010;
  localparam logic [OP_W-1:0] OP_NOR  = 4'b1011;
  localparam logic [OP_W-1:0] OP_XNOR = 4'b1100;
  localparam logic [OP_W-1:0] OP_GT   = 4'b1101;
  localparam logic [OP_W-1:0] OP_EQ   = 4'b1110;
  localparam logic [OP_W-1:0] OP_PASS = 4'b1111;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: computes next result and carry from the operands.
//   a, b     : unsigned operands (b unused by unary ops)
//   alu_sel  : opcode
//   res_c    : combinational result
//   carry_c  : combinational carry / borrow / shift-out flag
module alu_core
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [OP_W-1:0]   alu_sel,
  output logic [DATA_W-1:0] res_c,
  output logic              carry_c
);

  // One extra bit holds the add carry-out or the subtract borrow.
  logic [DATA_W:0] sum_ext;
  logic [DATA_W:0] diff_ext;

  assign sum_ext  = {1'b0, a} + {1'b0, b};
  assign diff_ext = {1'b0, a} - {1'b0, b};

  // Opcode decode; carry is zero unless the operation defines it.
  always_comb begin
    res_c   = '0;
    carry_c = 1'b0;
    case (alu_sel)
      OP_ADD:  begin
        res_c   = sum_ext[DATA_W-1:0];
        carry_c = sum_ext[DATA_W];
      end
      OP_SUB:  begin
        res_c   = diff_ext[DATA_W-1:0];
        carry_c = diff_ext[DATA_W];
      end
      OP_AND:  res_c = a & b;
      OP_OR:   res_c = a | b;
      OP_XOR:  res_c = a ^ b;
      OP_NOT:  res_c = ~a;
      OP_SHL:  begin
        res_c   = {a[DATA_W-2:0], 1'b0};
        carry_c = a[DATA_W-1];
      end
      OP_SHR:  begin
        res_c   = {1'b0, a[DATA_W-1:1]};
        carry_c = a[0];
      end
      OP_ROL:  res_c = {a[DATA_W-2:0], a[DATA_W-1]};
      OP_ROR:  res_c = {a[0], a[DATA_W-1:1]};
      OP_NAND: res_c = ~(a & b);
      OP_NOR:  res_c = ~(a | b);
      OP_XNOR: res_c = ~(a ^ b);
      OP_GT:   res_c = DATA_W'(a > b);
      OP_EQ:   res_c = DATA_W'(a == b);
      OP_PASS: res_c = a;
      default: begin
        res_c   = '0;
        carry_c = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu.sv
// Registered 8-bit execute-stage ALU: one operation per cycle, one-cycle latency.
//   clk, rst_n : clock and asynchronous active-low reset
//   A, B       : unsigned operands
//   ALU_Sel    : opcode
//   res        : registered result
//   carry      : registered carry / borrow / shift-out flag
module alu
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic [OP_W-1:0]   ALU_Sel,
  output logic [DATA_W-1:0] res,
  output logic              carry
);

  logic [DATA_W-1:0] res_d;
  logic [DATA_W-1:0] res_q;
  logic              carry_d;
  logic              carry_q;

  alu_core u_core (
    .a       (A),
    .b       (B),
    .alu_sel (ALU_Sel),
    .res_c   (res_d),
    .carry_c (carry_d)
  );

  // Output registers; reset clears them immediately and drops any in-flight op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      res_q   <= res_d;
      carry_q <= carry_d;
    end
  end

  assign res   = res_q;
  assign carry = carry_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vector table, reset sequences and a
// back-to-back sweep over all opcodes against an arithmetic reference model.
module tb_alu;
  import alu_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [7:0] a_in;
  logic [7:0] b_in;
  logic [3:0] sel_in;
  logic [7:0] res;
  logic       carry;

  int total;
  int bad;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] sel;
    logic [7:0] res;
    logic       carry;
  } vec_t;

  vec_t vecs[$];

  alu dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .A       (a_in),
    .B       (b_in),
    .ALU_Sel (sel_in),
    .res     (res),
    .carry   (carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] exp_res, input logic exp_c);
    total++;
    if (res !== exp_res || carry !== exp_c) begin
      bad++;
      $display("FAIL %s: got res=%02h carry=%b, want res=%02h carry=%b",
               name, res, carry, exp_res, exp_c);
    end
  endtask

  // Reference computed with integer arithmetic rather than bit slicing.
  function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b,
                                       input logic [3:0] sel);
    int ia, ib, r, c;
    ia = int'(a);
    ib = int'(b);
    c  = 0;
    case (sel)
      4'd0:  begin r = (ia + ib) % 256; c = (ia + ib > 255) ? 1 : 0; end
      4'd1:  begin r = (ia - ib + 256) % 256; c = (ia < ib) ? 1 : 0; end
      4'd2:  r = int'(a & b);
      4'd3:  r = int'(a | b);
      4'd4:  r = int'(a ^ b);
      4'd5:  r = 255 - ia;
      4'd6:  begin r = (ia * 2) % 256; c = ia / 128; end
      4'd7:  begin r = ia / 2; c = ia % 2; end
      4'd8:  r = (ia * 2) % 256 + ia / 128;
      4'd9:  r = ia / 2 + (ia % 2) * 128;
      4'd10: r = 255 - int'(a & b);
      4'd11: r = 255 - int'(a | b);
      4'd12: r = 255 - int'(a ^ b);
      4'd13: r = (ia > ib) ? 1 : 0;
      4'd14: r = (ia == ib) ? 1 : 0;
      default: r = ia;
    endcase
    return {1'(c), 8'(r)};
  endfunction

  initial begin
    logic [8:0] exp;
    logic [7:0] ra;
    logic [7:0] rb;

    total  = 0;
    bad    = 0;
    rst_n  = 1'b0;
    a_in   = 8'd0;
    b_in   = 8'd0;
    sel_in = OP_ADD;

    vecs.push_back('{8'd240, 8'd31,  OP_ADD,  8'd15,  1'b1});
    vecs.push_back('{8'd255, 8'd1,   OP_ADD,  8'd0,   1'b1});
    vecs.push_back('{8'd25,  8'd17,  OP_ADD,  8'd42,  1'b0});
    vecs.push_back('{8'd50,  8'd30,  OP_SUB,  8'd20,  1'b0});
    vecs.push_back('{8'd30,  8'd50,  OP_SUB,  8'd236, 1'b1});
    vecs.push_back('{8'd0,   8'd1,   OP_SUB,  8'd255, 1'b1});
    vecs.push_back('{8'd77,  8'd77,  OP_SUB,  8'd0,   1'b0});
    vecs.push_back('{8'hAA,  8'hCC,  OP_AND,  8'h88,  1'b0});
    vecs.push_back('{8'hAA,  8'hCC,  OP_OR,   8'hEE,  1'b0});
    vecs.push_back('{8'hF0,  8'h0F,  OP_XOR,  8'hFF,  1'b0});
    vecs.push_back('{8'hD5,  8'hFF,  OP_NOT,  8'h2A,  1'b0});
    vecs.push_back('{8'h0F,  8'h00,  OP_SHL,  8'h1E,  1'b0});
    vecs.push_back('{8'hF0,  8'h00,  OP_SHR,  8'h78,  1'b0});
    vecs.push_back('{8'h81,  8'h00,  OP_SHL,  8'h02,  1'b1});
    vecs.push_back('{8'h81,  8'h00,  OP_SHR,  8'h40,  1'b1});
    vecs.push_back('{8'h81,  8'hFF,  OP_ROL,  8'h03,  1'b0});
    vecs.push_back('{8'h81,  8'hFF,  OP_ROR,  8'hC0,  1'b0});
    vecs.push_back('{8'hAA,  8'hCC,  OP_NAND, 8'h77,  1'b0});
    vecs.push_back('{8'hAA,  8'hCC,  OP_NOR,  8'h11,  1'b0});
    vecs.push_back('{8'hF0,  8'h3C,  OP_XNOR, 8'h33,  1'b0});
    vecs.push_back('{8'd5,   8'd5,   OP_GT,   8'd0,   1'b0});
    vecs.push_back('{8'd6,   8'd5,   OP_GT,   8'd1,   1'b0});
    vecs.push_back('{8'd5,   8'd6,   OP_GT,   8'd0,   1'b0});
    vecs.push_back('{8'd5,   8'd5,   OP_EQ,   8'd1,   1'b0});
    vecs.push_back('{8'd5,   8'd6,   OP_EQ,   8'd0,   1'b0});
    vecs.push_back('{8'hA5,  8'h3C,  OP_PASS, 8'hA5,  1'b0});

    // Reset state, including across a clock edge while held.
    #2;
    check("reset_initial", 8'h00, 1'b0);
    a_in = 8'd240; b_in = 8'd31; sel_in = OP_ADD;
    @(posedge clk); #1;
    check("reset_held_edge", 8'h00, 1'b0);

    // Release on a falling edge; first capture on the following rising edge.
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("first_capture", 8'd15, 1'b1);

    // Hold between edges even when inputs change.
    @(negedge clk);
    a_in = 8'd1; b_in = 8'd2; sel_in = OP_SUB;
    #1;
    check("hold_between_edges", 8'd15, 1'b1);

    // Directed table applied back-to-back, one vector per cycle.
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      a_in   = vecs[i].a;
      b_in   = vecs[i].b;
      sel_in = vecs[i].sel;
      @(posedge clk); #1;
      check($sformatf("vec%0d_op%0d", i, vecs[i].sel), vecs[i].res, vecs[i].carry);
    end

    // Mid-stream asynchronous reset clears outputs before any clock edge.
    @(negedge clk);
    a_in = 8'd240; b_in = 8'd31; sel_in = OP_ADD;
    @(posedge clk); #1;
    check("pre_reset_value", 8'd15, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_clear", 8'h00, 1'b0);
    @(negedge clk);
    a_in = 8'd25; b_in = 8'd17; sel_in = OP_ADD;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset_add", 8'd42, 1'b0);

    // Back-to-back sweep over all 16 opcodes with random operands.
    for (int round = 0; round < 6; round++) begin
      for (int op = 0; op < 16; op++) begin
        ra = 8'($urandom_range(0, 255));
        rb = (round % 3 == 0) ? ra : 8'($urandom_range(0, 255));
        @(negedge clk);
        a_in   = ra;
        b_in   = rb;
        sel_in = 4'(op);
        exp    = model(ra, rb, 4'(op));
        @(posedge clk); #1;
        check($sformatf("rand_r%0d_op%0d_a%02h_b%02h", round, op, ra, rb),
              exp[7:0], exp[8]);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
